// File: rtl/vend_coin_driver.sv
// -----------------------------------------------------------------------------
// vend_coin_driver
//
// Payment sequencer for the vending machine. A command (valid/ready) carries a
// list of up to MAX_COINS coins; the driver sends them one at a time as
// single-cycle pulses on D_in (dollar) or Q_in (quarter). Consecutive pulses
// are separated by GAP idle cycles. After the last coin, responses are still
// watched for RESP_LAT cycles. A one-cycle done pulse then closes the command.
// While a command runs, Dispense and Change cycles are counted. A sticky err
// flag reports responses that arrive at the wrong time or in a wrong
// combination.
//
// Ports
//   clock       single clock, rising edge
//   rst         synchronous reset, active-high
//   cmd_valid   command offered
//   cmd_ready   command accepted when high (IDLE only)
//   cmd_coins   bit k = type of coin k (1 = dollar, 0 = quarter); coin 0 first
//   cmd_count   number of coins, clamped to MAX_COINS
//   D_in, Q_in  coin pulses to the vending machine
//   Dispense    vend indication from the vending machine
//   Change      change indication from the vending machine
//   busy        high whenever not IDLE
//   done        one-cycle completion pulse
//   vend_cnt    Dispense cycles counted for the current/last command
//   change_cnt  Change cycles counted for the current/last command
//   err         sticky protocol error flag
// -----------------------------------------------------------------------------
module vend_coin_driver #(
    parameter int MAX_COINS = 8,
    parameter int GAP       = 1,
    parameter int RESP_LAT  = 1,
    parameter int CW        = $clog2(MAX_COINS + 1)
) (
    input  logic                 clock,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [MAX_COINS-1:0] cmd_coins,
    input  logic [CW-1:0]        cmd_count,
    output logic                 D_in,
    output logic                 Q_in,
    input  logic                 Dispense,
    input  logic                 Change,
    output logic                 busy,
    output logic                 done,
    output logic [CW-1:0]        vend_cnt,
    output logic [CW-1:0]        change_cnt,
    output logic                 err
);

    // One down-counter serves both the gap and the drain waits. It is sized
    // so that it never collapses to zero width when GAP and RESP_LAT are 0.
    localparam int TMAX = (GAP > RESP_LAT) ? GAP : RESP_LAT;
    localparam int TW   = $clog2(TMAX + 2);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PULSE,
        ST_GAP_WAIT,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t               state_reg, state_next;
    logic [MAX_COINS-1:0] coins_reg, coins_next;
    logic [CW-1:0]        count_reg, count_next;
    logic [CW-1:0]        idx_reg, idx_next;
    logic [TW-1:0]        timer_reg, timer_next;
    logic [CW-1:0]        vend_cnt_reg, vend_cnt_next;
    logic [CW-1:0]        change_cnt_reg, change_cnt_next;
    logic                 err_reg, err_next;

    logic [CW-1:0]        count_clamped;
    logic [CW-1:0]        idx_plus;
    logic                 counting;

    assign count_clamped = (cmd_count > CW'(MAX_COINS)) ? CW'(MAX_COINS) : cmd_count;
    assign idx_plus      = idx_reg + CW'(1);
    assign counting      = (state_reg == ST_PULSE) || (state_reg == ST_GAP_WAIT) ||
                           (state_reg == ST_DRAIN);

    always_ff @(posedge clock) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            coins_reg      <= '0;
            count_reg      <= '0;
            idx_reg        <= '0;
            timer_reg      <= '0;
            vend_cnt_reg   <= '0;
            change_cnt_reg <= '0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            coins_reg      <= coins_next;
            count_reg      <= count_next;
            idx_reg        <= idx_next;
            timer_reg      <= timer_next;
            vend_cnt_reg   <= vend_cnt_next;
            change_cnt_reg <= change_cnt_next;
            err_reg        <= err_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        coins_next      = coins_reg;
        count_next      = count_reg;
        idx_next        = idx_reg;
        timer_next      = timer_reg;
        vend_cnt_next   = vend_cnt_reg;
        change_cnt_next = change_cnt_reg;
        err_next        = err_reg;

        // Saturating response counters, active only while a command is in flight.
        if (counting) begin
            if (Dispense && (vend_cnt_reg != '1))
                vend_cnt_next = vend_cnt_reg + CW'(1);
            if (Change && (change_cnt_reg != '1))
                change_cnt_next = change_cnt_reg + CW'(1);
        end

        // A response outside a command, or change without a vend, is a protocol error.
        if ((Dispense || Change) && ((state_reg == ST_IDLE) || (state_reg == ST_DONE)))
            err_next = 1'b1;
        if (Change && !Dispense)
            err_next = 1'b1;

        case (state_reg)
            ST_IDLE: begin
                if (cmd_valid) begin
                    coins_next      = cmd_coins;
                    count_next      = count_clamped;
                    idx_next        = '0;
                    vend_cnt_next   = '0;
                    change_cnt_next = '0;
                    // Acceptance starts a fresh error window for the new command.
                    err_next        = 1'b0;
                    state_next      = (count_clamped == '0) ? ST_DONE : ST_PULSE;
                end
            end
            ST_PULSE: begin
                // The current coin always sits in bit 0; shift for the next one.
                coins_next = coins_reg >> 1;
                idx_next   = idx_plus;
                if (idx_plus == count_reg) begin
                    if (RESP_LAT == 0) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_DRAIN;
                        timer_next = TW'(RESP_LAT - 1);
                    end
                end else if (GAP == 0) begin
                    state_next = ST_PULSE;
                end else begin
                    state_next = ST_GAP_WAIT;
                    timer_next = TW'(GAP - 1);
                end
            end
            ST_GAP_WAIT: begin
                if (timer_reg == '0)
                    state_next = ST_PULSE;
                else
                    timer_next = timer_reg - TW'(1);
            end
            ST_DRAIN: begin
                if (timer_reg == '0)
                    state_next = ST_DONE;
                else
                    timer_next = timer_reg - TW'(1);
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Every output is decoded from registered state only.
    assign cmd_ready  = (state_reg == ST_IDLE);
    assign busy       = (state_reg != ST_IDLE);
    assign done       = (state_reg == ST_DONE);
    assign D_in       = (state_reg == ST_PULSE) &&  coins_reg[0];
    assign Q_in       = (state_reg == ST_PULSE) && !coins_reg[0];
    assign vend_cnt   = vend_cnt_reg;
    assign change_cnt = change_cnt_reg;
    assign err        = err_reg;

endmodule

// File: tb/tb_vend_coin_driver.sv
// -----------------------------------------------------------------------------
// tb_vend_coin_driver
//
// Two driver instances (GAP=1 and GAP=0, both RESP_LAT=1, MAX_COINS=8). Each
// one feeds a small 75-cent vending machine model. When a command is driven,
// the expected coin pulses are pushed to a queue. Each observed pulse pops
// and compares one entry. A table of command records gives the expected done
// cycle and counter values. Hand-written sequences cover the error flag and
// a reset in the middle of a command.
// -----------------------------------------------------------------------------
module tb_vend_coin_driver;

    localparam int MC = 8;
    localparam int CW = $clog2(MC + 1);

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic          rst;
    logic          cmd_valid_0, cmd_valid_1;
    logic [MC-1:0] cmd_coins;
    logic [CW-1:0] cmd_count;
    logic          force_disp;

    logic          cmd_ready_0, d_in_0, q_in_0, busy_0, done_0, err_0;
    logic          cmd_ready_1, d_in_1, q_in_1, busy_1, done_1, err_1;
    logic [CW-1:0] vend_cnt_0, change_cnt_0, vend_cnt_1, change_cnt_1;
    logic          disp_0, chg_0, disp_1, chg_1;
    logic          dispense_0, change_0, dispense_1, change_1;

    assign dispense_0 = disp_0 | force_disp;
    assign change_0   = chg_0;
    assign dispense_1 = disp_1;
    assign change_1   = chg_1;

    vend_coin_driver #(.MAX_COINS(MC), .GAP(1), .RESP_LAT(1)) dut0 (
        .clock(clock), .rst(rst), .cmd_valid(cmd_valid_0), .cmd_ready(cmd_ready_0),
        .cmd_coins(cmd_coins), .cmd_count(cmd_count), .D_in(d_in_0), .Q_in(q_in_0),
        .Dispense(dispense_0), .Change(change_0), .busy(busy_0), .done(done_0),
        .vend_cnt(vend_cnt_0), .change_cnt(change_cnt_0), .err(err_0)
    );

    vend_coin_driver #(.MAX_COINS(MC), .GAP(0), .RESP_LAT(1)) dut1 (
        .clock(clock), .rst(rst), .cmd_valid(cmd_valid_1), .cmd_ready(cmd_ready_1),
        .cmd_coins(cmd_coins), .cmd_count(cmd_count), .D_in(d_in_1), .Q_in(q_in_1),
        .Dispense(dispense_1), .Change(change_1), .busy(busy_1), .done(done_1),
        .vend_cnt(vend_cnt_1), .change_cnt(change_cnt_1), .err(err_1)
    );

    // 75-cent vending machine: responds one cycle after the coin that reaches
    // the price, returning all excess as change.
    int credit_0, credit_1;
    always @(posedge clock) begin : vm0
        int amt;
        if (rst) begin
            credit_0 = 0; disp_0 <= 1'b0; chg_0 <= 1'b0;
        end else begin
            amt = credit_0 + (d_in_0 ? 100 : 0) + (q_in_0 ? 25 : 0);
            if (amt >= 75) begin
                disp_0 <= 1'b1; chg_0 <= (amt > 75); credit_0 = 0;
            end else begin
                disp_0 <= 1'b0; chg_0 <= 1'b0; credit_0 = amt;
            end
        end
    end
    always @(posedge clock) begin : vm1
        int amt;
        if (rst) begin
            credit_1 = 0; disp_1 <= 1'b0; chg_1 <= 1'b0;
        end else begin
            amt = credit_1 + (d_in_1 ? 100 : 0) + (q_in_1 ? 25 : 0);
            if (amt >= 75) begin
                disp_1 <= 1'b1; chg_1 <= (amt > 75); credit_1 = 0;
            end else begin
                disp_1 <= 1'b0; chg_1 <= 1'b0; credit_1 = amt;
            end
        end
    end

    typedef struct {
        int        sel;
        logic [7:0] coins;
        logic [3:0] count;
        bit        hold;
        int        exp_done;
        int        exp_vend;
        int        exp_chg;
    } vec_t;

    typedef struct {
        int cyc;
        bit is_d;
    } pulse_t;

    vec_t   vecs[6];
    pulse_t exp_q[$];
    int     errors = 0;
    int     checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic sample(input int sel, output logic d, output logic q, output logic dn,
                          output logic bs, output logic rd, output logic er,
                          output int vc, output int cc);
        if (sel == 0) begin
            d = d_in_0; q = q_in_0; dn = done_0; bs = busy_0; rd = cmd_ready_0;
            er = err_0; vc = int'(vend_cnt_0); cc = int'(change_cnt_0);
        end else begin
            d = d_in_1; q = q_in_1; dn = done_1; bs = busy_1; rd = cmd_ready_1;
            er = err_1; vc = int'(vend_cnt_1); cc = int'(change_cnt_1);
        end
    endtask

    task automatic run_cmd(input vec_t v);
        int n, gap;
        bit seen_done;
        logic d, q, dn, bs, rd, er;
        int vc, cc;
        pulse_t p;
        n   = (v.count > 4'd8) ? 8 : int'(v.count);
        gap = (v.sel == 0) ? 1 : 0;
        exp_q.delete();
        for (int k = 0; k < n; k++) begin
            p.cyc  = 1 + k * (gap + 1);
            p.is_d = v.coins[k];
            exp_q.push_back(p);
        end
        @(negedge clock);
        cmd_coins = v.coins;
        cmd_count = v.count;
        if (v.sel == 0) cmd_valid_0 = 1'b1; else cmd_valid_1 = 1'b1;
        @(negedge clock);
        if (!v.hold) begin cmd_valid_0 = 1'b0; cmd_valid_1 = 1'b0; end
        seen_done = 0;
        for (int c = 1; c <= 40 && !seen_done; c++) begin
            sample(v.sel, d, q, dn, bs, rd, er, vc, cc);
            if (c == 1) chk("err_clear_on_accept", int'(er), 0);
            chk("no_overlap", int'(d & q), 0);
            if (d | q) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_pulse: got pulse in cycle %0d expected none", c);
                end else begin
                    p = exp_q.pop_front();
                    chk("pulse_cycle", c, p.cyc);
                    chk("pulse_type_d", int'(d), int'(p.is_d));
                end
            end
            if (dn) begin
                seen_done = 1;
                chk("done_cycle", c, v.exp_done);
                chk("vend_cnt", vc, v.exp_vend);
                chk("change_cnt", cc, v.exp_chg);
                chk("err_at_done", int'(er), 0);
                chk("pulses_missing", exp_q.size(), 0);
                cmd_valid_0 = 1'b0; cmd_valid_1 = 1'b0;
            end else begin
                chk("busy_while_running", int'(bs), 1);
                chk("ready_while_running", int'(rd), 0);
            end
            @(negedge clock);
        end
        if (!seen_done) begin
            checks++; errors++;
            $display("FAIL done_timeout: got no done within 40 cycles expected cycle %0d", v.exp_done);
            cmd_valid_0 = 1'b0; cmd_valid_1 = 1'b0;
        end
        sample(v.sel, d, q, dn, bs, rd, er, vc, cc);
        chk("idle_ready_after_done", int'(rd), 1);
        chk("idle_done_low", int'(dn), 0);
        chk("vend_cnt_held", vc, v.exp_vend);
        $display("cmd sel=%0d coins=%h count=%0d vend=%0d change=%0d", v.sel, v.coins, v.count, vc, cc);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish expected finish before 300us");
        $fatal(1);
    end

    initial begin
        logic d, q, dn, bs, rd, er;
        int vc, cc, pulses;

        //            sel coins  cnt  hold done vend chg
        vecs[0] = '{0, 8'h00, 4'd3,  0,  7,  1, 0};   // Q,Q,Q
        vecs[1] = '{0, 8'h01, 4'd1,  0,  3,  1, 1};   // D
        vecs[2] = '{1, 8'h02, 4'd5,  1,  7,  2, 1};   // Q,D,Q,Q,Q back-to-back, valid held
        vecs[3] = '{0, 8'h00, 4'd0,  0,  1,  0, 0};   // empty command
        vecs[4] = '{0, 8'hFF, 4'd12, 0, 17,  8, 8};   // over-long, clamps to 8 dollars
        vecs[5] = '{0, 8'h01, 4'd1,  0,  3,  1, 1};   // D after forced error

        rst = 1'b1; cmd_valid_0 = 1'b0; cmd_valid_1 = 1'b0;
        cmd_coins = '0; cmd_count = '0; force_disp = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        rst = 1'b0;
        for (int s = 0; s < 2; s++) begin
            sample(s, d, q, dn, bs, rd, er, vc, cc);
            chk("rst_coin_pulses", int'(d | q), 0);
            chk("rst_done", int'(dn), 0);
            chk("rst_busy", int'(bs), 0);
            chk("rst_err", int'(er), 0);
            chk("rst_counts", vc + cc, 0);
            chk("rst_ready", int'(rd), 1);
        end
        pulses = 0;
        repeat (20) begin
            @(negedge clock);
            pulses += int'(d_in_0 | q_in_0 | d_in_1 | q_in_1);
        end
        chk("idle_no_pulses_20_cycles", pulses, 0);
        $display("reset/idle sequence done");

        for (int i = 0; i < 5; i++) run_cmd(vecs[i]);

        // Dispense while idle sets the sticky error; the next command clears it.
        @(negedge clock);
        force_disp = 1'b1;
        @(negedge clock);
        force_disp = 1'b0;
        chk("err_set_idle_dispense", int'(err_0), 1);
        repeat (3) @(negedge clock);
        chk("err_sticky", int'(err_0), 1);
        $display("forced idle dispense err=%0d", err_0);
        run_cmd(vecs[5]);

        // Reset right after the second of five pulses aborts the command.
        @(negedge clock);
        cmd_coins = 8'h00; cmd_count = 4'd5; cmd_valid_0 = 1'b1;
        @(negedge clock);
        cmd_valid_0 = 1'b0;
        pulses = 0;
        for (int c = 1; c <= 3; c++) begin
            pulses += int'(d_in_0 | q_in_0);
            if (c < 3) @(negedge clock);
        end
        chk("pulses_before_rst", pulses, 2);
        rst = 1'b1;
        @(negedge clock);
        rst = 1'b0;
        pulses = 0;
        bs = 1'b0;
        dn = 1'b0;
        repeat (15) begin
            pulses += int'(d_in_0 | q_in_0);
            bs = bs | busy_0;
            dn = dn | done_0;
            @(negedge clock);
        end
        chk("abort_no_pulses", pulses, 0);
        chk("abort_no_done", int'(dn), 0);
        chk("abort_not_busy", int'(bs), 0);
        chk("abort_counts_clear", int'(vend_cnt_0), 0);
        $display("mid-command reset sequence done");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
